// File: rtl/data_lsu_if.sv
// Core-side request/response bundle and LSU-to-data_ram bus for data_lsu.
// data_lsu_if : req_valid/req_ready handshake with we/op/addr/wdata; single-cycle rsp_valid with rdata/err.
// lsu_ram_if  : wen_n (active-low write), mem_op, word addr, din towards the RAM; dout back (one-cycle read latency).

interface data_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lsu_ram_if;
    logic        wen_n;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (
        output wen_n, mem_op, addr, din,
        input  dout
    );

    modport slave (
        input  wen_n, mem_op, addr, din,
        output dout
    );
endinterface

// File: rtl/data_lsu.sv
// Load/store unit: byte-addressed loads/stores to data_ram with lane extract, extension, sub-word RMW.
// Latency from accept: error 1, load 3, direct store 2, read-modify-write store 4 cycles to rsp_valid.
// One request in flight; req_ready only in IDLE; response is a one-cycle pulse with no backpressure.
//
// Ports: clk, rst (synchronous, active-high); core (data_lsu_if.slave): request/response;
//        ram (lsu_ram_if.master): wen_n/mem_op/addr/din out, dout in.
// Optional feature: define DATA_LSU_RANGE_CHECK_EN to reject addresses beyond the 2 KiB RAM.

module data_lsu (
    input  logic      clk,
    input  logic      rst,
    data_lsu_if.slave core,
    lsu_ram_if.master ram
);

    typedef enum logic [2:0] {
        IDLE,
        LD_A,
        LD_D,
        RMW_A,
        RMW_D,
        ST_W,
        RSP
    } state_t;

    localparam logic [2:0] OP_WORD = 3'b010;

    state_t      state_q,     state_d;
    logic [2:0]  op_q,        op_d;
    logic [1:0]  off_q,       off_d;
    logic [31:0] wdata_q,     wdata_d;
    logic        rmw_q,       rmw_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        wen_n_q,     wen_n_d;
    logic [2:0]  mem_op_q,    mem_op_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] din_q,       din_d;

    logic        accept;
    logic        op_legal;
    logic        misaligned;
    logic        range_err;
    logic        req_err;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic [31:0] st_merged;

    assign accept = core.req_valid & req_ready_q;

`ifdef DATA_LSU_RANGE_CHECK_EN
    assign range_err = |core.req_addr[31:11];
`else
    // Upper bits are simply dropped by the RAM's 9-bit word index (aliasing).
    assign range_err = 1'b0;
`endif

    always_comb begin
        op_legal = 1'b0;
        case (core.req_op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
        misaligned = ((core.req_op[1:0] == 2'b01) && core.req_addr[0]) ||
                     ((core.req_op[1:0] == 2'b10) && (core.req_addr[1:0] != 2'b00));
        req_err    = !op_legal || misaligned || range_err;
    end

    // Load lane extraction: shift the addressed lane down, then extend per op.
    assign ld_shift = ram.dout >> {off_q, 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        case (op_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // RMW merge. Only reached with off != 0; a legal half store then sits at off == 2.
    always_comb begin
        st_merged = ram.dout;
        if (op_q[1:0] == 2'b00) begin
            st_merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            st_merged[31:16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rmw_d       = rmw_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        din_d       = din_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d        = core.req_op;
                    off_d       = core.req_addr[1:0];
                    wdata_d     = core.req_wdata;
                    addr_d      = {2'b00, core.req_addr[31:2]};
                    din_d       = core.req_wdata;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = req_err;
                    rmw_d       = core.req_we && (core.req_op[1:0] != 2'b10) &&
                                  (core.req_addr[1:0] != 2'b00);
                    if (req_err) begin
                        state_d = RSP;
                    end else if (!core.req_we) begin
                        state_d = LD_A;
                    end else if (rmw_d) begin
                        state_d = RMW_A;
                    end else begin
                        state_d = ST_W;
                    end
                end
            end
            LD_A:  state_d = LD_D;
            LD_D: begin
                rsp_rdata_d = ld_ext;
                state_d     = RSP;
            end
            RMW_A: state_d = RMW_D;
            RMW_D: begin
                din_d   = st_merged;
                state_d = ST_W;
            end
            ST_W:  state_d = RSP;
            RSP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered off the next state so they line up with it.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP);
        wen_n_d     = (state_d != ST_W);
        // A direct store lets the RAM mask lanes; a merged word goes out as a full word.
        mem_op_d    = ((state_d == ST_W) && !rmw_d) ? op_d : OP_WORD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_WORD;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            rmw_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            wen_n_q     <= 1'b1;
            mem_op_q    <= OP_WORD;
            addr_q      <= 32'h0;
            din_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            rmw_q       <= rmw_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wen_n_q     <= wen_n_d;
            mem_op_q    <= mem_op_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign core.req_ready = req_ready_q;
    assign core.rsp_valid = rsp_valid_q;
    assign core.rsp_err   = rsp_err_q;
    assign core.rsp_rdata = rsp_rdata_q;

    // Reset is synchronous, so a reset landing in ST_W would still see wen_n_q low
    // for that cycle; gate it directly so no write escapes.
    assign ram.wen_n  = wen_n_q | rst;
    assign ram.mem_op = mem_op_q;
    assign ram.addr   = addr_q;
    assign ram.din    = din_q;

endmodule

// File: tb/tb_data_lsu.sv
// Testbench for data_lsu: behavioural data_ram plus a transaction-level memory model.

module tb_data_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_lsu_if core_if ();
    lsu_ram_if  ram_if ();

    data_lsu dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_if),
        .ram  (ram_if)
    );

    // ---------------- data_ram stand-in: one-cycle read, lane-masked write ----------------
    logic [31:0] ram_mem [512];
    logic [31:0] ram_dout_r;
    assign ram_if.dout = ram_dout_r;

    always @(posedge clk) begin
        if (ram_if.wen_n == 1'b0) begin
            case (ram_if.mem_op)
                3'b000, 3'b100: ram_mem[ram_if.addr[8:0]][7:0]  <= ram_if.din[7:0];
                3'b001, 3'b101: ram_mem[ram_if.addr[8:0]][15:0] <= ram_if.din[15:0];
                default:        ram_mem[ram_if.addr[8:0]]       <= ram_if.din;
            endcase
        end
        ram_dout_r <= ram_mem[ram_if.addr[8:0]];
    end

    // ---------------- bus monitor ----------------
    int          cyc;
    int          wr_cnt;
    int          rsp_cnt;
    int          wr_cyc;
    logic [31:0] wr_din;
    logic [31:0] wr_addr;
    logic [2:0]  wr_op;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_if.wen_n == 1'b0) begin
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_din  <= ram_if.din;
            wr_addr <= ram_if.addr;
            wr_op   <= ram_if.mem_op;
        end
        if (core_if.rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: memory as a word array, byte-lane arithmetic ----------------
    logic [31:0] mdl [512];

    task automatic model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                         output int lat, output logic [31:0] wr_word, output logic [2:0] wr_mop);
        int          off;
        int          size;
        int          idx;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        off     = int'(addr[1:0]);
        idx     = int'(addr[10:2]);
        w       = mdl[idx];
        size    = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        err     = !(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (size == 2 && (off % 2) != 0) ||
                  (size == 4 && off != 0);
`ifdef DATA_LSU_RANGE_CHECK_EN
        if (addr[31:11] != 21'h0) err = 1'b1;
`endif
        rdata   = 32'h0;
        lat     = 1;
        wr_word = 32'h0;
        wr_mop  = 3'b010;
        if (err) return;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        if (!we) begin
            lat = 3;
            v   = (w >> (8 * off)) & mask;
            if (!op[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
            rdata = v;
        end else begin
            mdl[idx] = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            if (off == 0) begin
                lat     = 2;
                wr_word = wd;
                wr_mop  = op;
            end else begin
                lat     = 4;
                wr_word = mdl[idx];
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 32'(core_if.req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(core_if.rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, core_if.rsp_rdata, 32'h0);
        check({tag, "_rsp_err"},   32'(core_if.rsp_err), 32'd0);
        check({tag, "_wen_n"},     32'(ram_if.wen_n), 32'd1);
        check({tag, "_mem_op"},    32'(ram_if.mem_op), 32'd2);
        check({tag, "_ram_addr"},  ram_if.addr, 32'h0);
        check({tag, "_ram_din"},   ram_if.din, 32'h0);
    endtask

    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_wword;
        logic [2:0]  e_mop;
        int          e_lat;
        int          lat;
        int          acc;
        int          wc0;
        int          idx;
        model(we, op, addr, wd, e_err, e_rdata, e_lat, e_wword, e_mop);
        idx = int'(addr[10:2]);
        wc0 = wr_cnt;
        @(negedge clk);
        check("req_ready", 32'(core_if.req_ready), 32'd1);
        core_if.req_valid = 1'b1;
        core_if.req_we    = we;
        core_if.req_op    = op;
        core_if.req_addr  = addr;
        core_if.req_wdata = wd;
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        core_if.req_valid = 1'b0;
        lat = 1;
        while (core_if.rsp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid", 32'(core_if.rsp_valid), 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("rsp_err", 32'(core_if.rsp_err), 32'(e_err));
        check("rsp_rdata", core_if.rsp_rdata, e_rdata);
        if (we && !e_err) begin
            check("wr_count", 32'(wr_cnt - wc0), 32'd1);
            check("wr_slot", 32'(wr_cyc - acc), 32'(e_lat - 2));
            check("wr_din", wr_din, e_wword);
            check("wr_op", 32'(wr_op), 32'(e_mop));
            check("wr_addr", wr_addr, {2'b00, addr[31:2]});
        end else begin
            check("no_write", 32'(wr_cnt - wc0), 32'd0);
        end
        @(negedge clk);
        check("rsp_pulse", 32'(core_if.rsp_valid), 32'd0);
        check("ready_after", 32'(core_if.req_ready), 32'd1);
        check("mem_word", ram_mem[idx], mdl[idx]);
    endtask

    // Byte store at an odd lane with reset raised during cycle N+at (2 = merge, 3 = write).
    task automatic rst_abort(input int at);
        int wc0;
        int rc0;
        wc0 = wr_cnt;
        rc0 = rsp_cnt;
        @(negedge clk);
        core_if.req_valid = 1'b1;
        core_if.req_we    = 1'b1;
        core_if.req_op    = 3'b000;
        core_if.req_addr  = 32'h41;
        core_if.req_wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        core_if.req_valid = 1'b0;
        for (int k = 1; k < at; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("abort");
        repeat (5) @(negedge clk);
        check("abort_no_write", 32'(wr_cnt - wc0), 32'd0);
        check("abort_no_rsp", 32'(rsp_cnt - rc0), 32'd0);
        check("abort_mem", ram_mem[16], mdl[16]);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 32'h0;
            mdl[i]     = 32'h0;
        end
        core_if.req_valid = 1'b0;
        core_if.req_we    = 1'b0;
        core_if.req_op    = 3'b010;
        core_if.req_addr  = 32'h0;
        core_if.req_wdata = 32'h0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Word store then load.
        do_req(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        // Lane extraction and extension.
        do_req(1'b1, 3'b010, 32'h40, 32'h80FF1234);
        do_req(1'b0, 3'b000, 32'h43, 32'h0);
        do_req(1'b0, 3'b100, 32'h43, 32'h0);
        do_req(1'b0, 3'b001, 32'h42, 32'h0);
        do_req(1'b0, 3'b101, 32'h40, 32'h0);
        // Sub-word stores: RMW at off 1, direct half at off 0.
        do_req(1'b1, 3'b010, 32'h40, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h41, 32'hFFFFFFAA);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        do_req(1'b1, 3'b010, 32'h40, 32'h11223344);
        do_req(1'b1, 3'b001, 32'h40, 32'h00005566);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        // Errors.
        do_req(1'b0, 3'b001, 32'h41, 32'h0);
        do_req(1'b0, 3'b010, 32'h42, 32'h0);
        do_req(1'b1, 3'b011, 32'h40, 32'h12345678);
        do_req(1'b1, 3'b001, 32'h43, 32'h12345678);
        // Reset mid-RMW (merge cycle, then write cycle).
        do_req(1'b1, 3'b010, 32'h40, 32'h11223344);
        rst_abort(2);
        rst_abort(3);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        // Out-of-range store: aliases to word 0, or errors with the range check.
        do_req(1'b1, 3'b010, 32'h800, 32'h12345678);
        do_req(1'b0, 3'b010, 32'h0, 32'h0);

        // Randomized traffic over a small window, sometimes with upper address bits set.
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | (32'h800 << $urandom_range(0, 20));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
